// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
// The decoder drives mdop using the same MD_* values.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } mdop_t;

  typedef enum logic {
    MDS_IDLE = 1'b0,
    MDS_BUSY = 1'b1
  } mds_t;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: 64-bit {hi,lo} result and divide-by-zero flag.
// Division returns quotient in lo and remainder in hi, truncating toward zero.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  mdop,
  output logic [63:0] result,
  output logic        divzero
);

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic        [31:0] b_safe;
  logic signed [31:0] squot;
  logic signed [31:0] srem;

  assign sprod  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod  = {32'd0, a} * {32'd0, b};
  // A zero divisor is replaced so the dividers never see it; the result is discarded anyway.
  assign b_safe = (b == 32'd0) ? 32'd1 : b;

  always_comb begin
    squot = $signed(a) / $signed(b_safe);
    srem  = $signed(a) % $signed(b_safe);
    // Divisor -1 is handled explicitly so the most-negative dividend wraps instead of trapping.
    if (b_safe == 32'hFFFF_FFFF) begin
      squot = $signed(32'd0 - a);
      srem  = '0;
    end
  end

  always_comb begin
    result  = '0;
    divzero = 1'b0;
    case (mdop)
      MD_MULT:  result = sprod;
      MD_MULTU: result = uprod;
      MD_DIV: begin
        result  = {srem, squot};
        divzero = (b == 32'd0);
      end
      MD_DIVU: begin
        result  = {a % b_safe, a / b_safe};
        divzero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer: latches the result on accept, holds busy for a
// fixed latency, then commits to the architectural HI/LO registers.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  mds_t          state_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   ph_reg;
  logic [31:0]   pl_reg;
  logic          nocommit_reg;
  logic          busy_reg;
  logic [31:0]   hi_reg;
  logic [31:0]   lo_reg;

  logic [63:0]   result;
  logic          divzero;

  mdu_arith u_arith (
    .a       (a),
    .b       (b),
    .mdop    (mdop),
    .result  (result),
    .divzero (divzero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= MDS_IDLE;
      count_reg    <= '0;
      ph_reg       <= '0;
      pl_reg       <= '0;
      nocommit_reg <= 1'b0;
      busy_reg     <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      case (state_reg)
        MDS_IDLE: begin
          if (start && !cancel) begin
            case (mdop)
              MD_MULT, MD_MULTU: begin
                ph_reg       <= result[63:32];
                pl_reg       <= result[31:0];
                nocommit_reg <= 1'b0;
                count_reg    <= CW'(MULT_CYCLES);
                state_reg    <= MDS_BUSY;
                busy_reg     <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                ph_reg       <= result[63:32];
                pl_reg       <= result[31:0];
                nocommit_reg <= divzero;
                count_reg    <= CW'(DIV_CYCLES);
                state_reg    <= MDS_BUSY;
                busy_reg     <= 1'b1;
              end
              MD_MTHI: hi_reg <= a;
              MD_MTLO: lo_reg <= a;
              default: ;
            endcase
          end
        end
        MDS_BUSY: begin
          // Starts arriving here are ignored; the op in flight always runs to completion.
          if (count_reg == CW'(1)) begin
            if (!nocommit_reg) begin
              hi_reg <= ph_reg;
              lo_reg <= pl_reg;
            end
            count_reg <= '0;
            state_reg <= MDS_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= MDS_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized ops against
// an arithmetic reference model of HI/LO and busy latency.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdop   (mdop),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  // Presents one start pulse; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic c);
    @(negedge clk);
    start = 1'b1; mdop = op; a = x; b = y; cancel = c;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; mdop = MD_NONE;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 60) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  function automatic int exp_cycles(input logic [2:0] op);
    case (op)
      MD_MULT, MD_MULTU: return MULT_CYCLES;
      MD_DIV, MD_DIVU:   return DIV_CYCLES;
      default:           return 0;
    endcase
  endfunction

  function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      MD_MULT: begin
        q = sx * sy;
        hi_m = q[63:32]; lo_m = q[31:0];
      end
      MD_MULTU: begin
        p = {32'd0, x} * {32'd0, y};
        hi_m = p[63:32]; lo_m = p[31:0];
      end
      MD_DIV: if (y != 0) begin
        q = sx / sy; r = sx % sy;
        lo_m = q[31:0]; hi_m = r[31:0];
      end
      MD_DIVU: if (y != 0) begin
        lo_m = x / y; hi_m = x % y;
      end
      MD_MTHI: hi_m = x;
      MD_MTLO: lo_m = x;
      default: ;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; mdop = MD_MULT; a = 32'd3; b = 32'd4; cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo);
    end
    @(negedge clk);
    reset = 1'b1; start = 1'b0; mdop = MD_NONE;
    hi_m = '0; lo_m = '0;
    $display("reset: busy=%0b hi=%h lo=%h", busy, hi, lo);
  endtask

  task automatic test_mult(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                           input int cyc_w, input logic [31:0] hi_w, input logic [31:0] lo_w,
                           input string name);
    int cyc;
    issue(op, x, y, 1'b0);
    model(op, x, y);
    wait_idle(cyc);
    n_checks++;
    if (cyc !== cyc_w) begin n_fail++; $display("FAIL %s_busy got %0d want %0d", name, cyc, cyc_w); end
    n_checks++;
    if (hi !== hi_w || lo !== lo_w) begin
      n_fail++; $display("FAIL %s_hilo got %h/%h want %h/%h", name, hi, lo, hi_w, lo_w);
    end
    $display("%s a=%h b=%h: busy=%0d hi=%h lo=%h", name, x, y, cyc, hi, lo);
  endtask

  task automatic test_mthi_divzero();
    int cyc;
    logic [31:0] lo_prev;
    lo_prev = lo_m;
    issue(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    model(MD_MTHI, 32'h1234_5678, 32'd0);
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h1234_5678) begin
      n_fail++; $display("FAIL mthi got busy=%0b hi=%h want 0/12345678", busy, hi);
    end
    $display("mthi: busy=%0b hi=%h", busy, hi);
    issue(MD_DIVU, 32'd5, 32'd0, 1'b0);
    wait_idle(cyc);
    n_checks++;
    if (cyc !== DIV_CYCLES) begin n_fail++; $display("FAIL divzero_busy got %0d want %0d", cyc, DIV_CYCLES); end
    n_checks++;
    if (hi !== 32'h1234_5678 || lo !== lo_prev) begin
      n_fail++; $display("FAIL divzero_hilo got %h/%h want 12345678/%h", hi, lo, lo_prev);
    end
    $display("divu by zero: busy=%0d hi=%h lo=%h", cyc, hi, lo);
  endtask

  task automatic test_cancel();
    issue(MD_MULT, 32'd7, 32'd9, 1'b1);
    n_checks++;
    if (busy !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
      n_fail++; $display("FAIL cancel got busy=%0b hi=%h lo=%h want 0/%h/%h", busy, hi, lo, hi_m, lo_m);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_late got busy=%0b want 0", busy); end
    $display("cancelled mult: busy=%0b hi=%h lo=%h", busy, hi, lo);
  endtask

  task automatic test_busy_ignore();
    int cyc;
    issue(MD_MULT, 32'd3, 32'd4, 1'b0);
    model(MD_MULT, 32'd3, 32'd4);
    @(negedge clk);
    start = 1'b1; mdop = MD_MULT; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0; mdop = MD_NONE;
    wait_idle(cyc);
    n_checks++;
    if (cyc !== MULT_CYCLES - 1) begin
      n_fail++; $display("FAIL ignore_busy got %0d want %0d", cyc, MULT_CYCLES - 1);
    end
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd12) begin
      n_fail++; $display("FAIL ignore_hilo got %h/%h want 0/0000000c", hi, lo);
    end
    $display("start during busy: remaining busy=%0d hi=%h lo=%h", cyc, hi, lo);
  endtask

  task automatic test_reset_mid();
    int bad;
    issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid got busy=%0b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    hi_m = '0; lo_m = '0;
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_nocommit got %0d bad cycles want 0", bad); end
    $display("reset mid-divu: busy=%0b hi=%h lo=%h", busy, hi, lo);
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [31:0] x, y;
    logic c;
    int cyc, want;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 6));
      x  = $urandom;
      y  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 4) == 0) y = 32'($urandom_range(1, 9));
      c  = ($urandom_range(0, 7) == 0);
      issue(op, x, y, c);
      want = c ? 0 : exp_cycles(op);
      if (!c) model(op, x, y);
      wait_idle(cyc);
      n_checks++;
      if (cyc !== want) begin n_fail++; $display("FAIL rand%0d_busy got %0d want %0d", i, cyc, want); end
      n_checks++;
      if (hi !== hi_m || lo !== lo_m) begin
        n_fail++; $display("FAIL rand%0d_hilo got %h/%h want %h/%h", i, hi, lo, hi_m, lo_m);
      end
      $display("rand%0d op=%0d a=%h b=%h cancel=%0b: busy=%0d hi=%h lo=%h", i, op, x, y, c, cyc, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    model(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_idle(cyc);
    issue(MD_DIV, 32'd1000, 32'hFFFF_FFF9, 1'b0);
    model(MD_DIV, 32'd1000, 32'hFFFF_FFF9);
    n_checks++;
    if (busy !== 1'b1 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      n_fail++; $display("FAIL b2b_first got busy=%0b hi=%h lo=%h want 1/ffffffff/ffffffeb", busy, hi, lo);
    end
    wait_idle(cyc);
    n_checks++;
    if (cyc !== DIV_CYCLES || hi !== 32'd6 || lo !== 32'hFFFF_FF72) begin
      n_fail++; $display("FAIL b2b_second got busy=%0d hi=%h lo=%h want %0d/6/ffffff72", cyc, hi, lo, DIV_CYCLES);
    end
    n_checks++;
    if (hi !== hi_m || lo !== lo_m) begin
      n_fail++; $display("FAIL b2b_model got %h/%h want %h/%h", hi, lo, hi_m, lo_m);
    end
    $display("back-to-back mult,div: busy=%0d hi=%h lo=%h", cyc, hi, lo);
  endtask

  initial begin
    test_reset();
    test_mult(MD_MULT,  32'hFFFF_FFFF, 32'd2, MULT_CYCLES, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
    test_mult(MD_MULTU, 32'hFFFF_FFFF, 32'd2, MULT_CYCLES, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
    test_mult(MD_DIV,   32'hFFFF_FFF9, 32'd2, DIV_CYCLES,  32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    test_mthi_divzero();
    test_cancel();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
